h75_fb_write_arbiter: RTL and testbench
=======================================

// Module: h75_fb_write_arbiter
// PURPOSE
//  Single-clock controller between two framebuffer writers (port0: APB host, single beats; port1: DMA/pattern
//  source, bursts) and the one HUB75 framebuffer write port (wr_en/wr_addr[14:0]/wr_data[15:0]).
//  Owns double buffering: writes always target the back page, wr_addr[14] = ~display_page.
//  Page swap is requested by software and committed only on frame_sync, so the panel never shows a torn frame.
// PARAMETERS
//  ADDR_W     14  per-page word address width (wr_addr width = ADDR_W+1)
//  DATA_W     16  write data width
//  MAX_BURST  8   max port1 beats per grant before re-arbitration (>=1)
// PORTS
//  clk           in   1        memory-side clock (50 MHz)
//  reset         in   1        synchronous, active-high
//  req0          in   1        port0 write request; addr0/data0 held stable until ack0
//  addr0         in   ADDR_W   port0 in-page address
//  data0         in   DATA_W   port0 write data
//  ack0          out  1        port0 beat accepted this cycle (combinational)
//  req1          in   1        port1 write request; addr1/data1/last1 held stable until ack1
//  addr1         in   ADDR_W   port1 in-page address
//  data1         in   DATA_W   port1 write data
//  last1         in   1        final beat of port1 burst
//  ack1          out  1        port1 beat accepted this cycle (combinational)
//  swap_req      in   1        1-cycle pulse: request display/back page swap
//  frame_sync    in   1        1-cycle pulse, already in clk domain: frame boundary
//  swap_pending  out  1        swap requested, not yet committed
//  swap_done     out  1        1-cycle pulse in the cycle display_page changes
//  display_page  out  1        page currently scanned out
//  wr_en         out  1        framebuffer write strobe (registered)
//  wr_addr       out  ADDR_W+1 {back page, in-page addr} (registered)
//  wr_data       out  DATA_W   registered write data
// BEHAVIOUR
//  Reset: state=IDLE, rr_last=1 (port0 wins first tie), beat_cnt=0, display_page=0, swap_pending=0,
//   swap_done=0, wr_en=0, wr_addr=0, wr_data=0; ack0=ack1=0 whenever reset=1 (gated).
//   Reset mid-burst abandons the burst; no write issued for that cycle.
//  Handshake: ackN = reqN & grantN in the same cycle; at most one ack per cycle. Accepted beat appears on
//   wr_en/wr_addr/wr_data the next cycle (latency 1, throughput 1 beat/cycle). Page bit = ~display_page
//   sampled in the accept cycle. No accept -> wr_en=0 next cycle, wr_addr/wr_data hold.
//  FSM IDLE: if swap_pending -> no grants (fence). Else only req0 -> ack0; only req1 -> ack1;
//   both -> port != rr_last wins. Port0 grant: rr_last<=0, stay IDLE. Port1 grant: rr_last<=1, beat_cnt<=1;
//   if last1 or MAX_BURST==1 -> IDLE else -> BURST1.
//  FSM BURST1: ack1 = req1 (port0 waits; fence ignored). Each ack: beat_cnt++; exit to IDLE on ack with
//   last1, or on ack when beat_cnt+1 == MAX_BURST (burst cap; source resumes via new arbitration).
//   req1 low in BURST1: wait indefinitely, no ack.
//  Swap: swap_req sets swap_pending (ignored if already set). Commit when frame_sync & swap_pending &
//   state==IDLE: next edge display_page toggles, swap_pending clears, swap_done=1 for one cycle.
//   frame_sync while in BURST1 or without pending: no effect (waits for next frame_sync).
//   swap_req and frame_sync in same cycle: pending set, no commit that cycle.
//  beat_cnt width = clog2(MAX_BURST+1); never wraps.
// TESTING
//  1 Reset 2 cycles with req0=1,req1=1 -> ack0=ack1=0, wr_en=0, display_page=0, swap_pending=0.
//  2 req0, addr0=0x0123, data0=0xBEEF from idle -> ack0 same cycle; next cycle wr_en=1, wr_addr=0x4123, wr_data=0xBEEF.
//  3 req0 and req1 held, port1 burst 3 beats (last1 on 3rd) -> accept order P0,P1,P1,P1,P0 on consecutive cycles.
//  4 req1 held, last1=0 forever, req0 held -> 8 consecutive ack1, then one ack0, then ack1 resumes.
//  5 swap_req, idle, frame_sync 10 cycles later -> swap_pending=1 and req0 not acked meanwhile; edge after
//    frame_sync: display_page=1, swap_done pulse, pending req0 then acked with wr_addr[14]=0.
//  6 swap_req then frame_sync mid 8-beat port1 burst -> burst completes on page 1, no toggle; next frame_sync -> toggle.

Source files
------------

// File: rtl/h75_fb_write_arbiter_if.sv
// Bus bundle between the two framebuffer writers, the swap control and the HUB75 framebuffer write port.
interface h75_fb_write_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              last1;
  logic              ack1;
  logic              swap_req;
  logic              frame_sync;
  logic              swap_pending;
  logic              swap_done;
  logic              display_page;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req0, addr0, data0, req1, addr1, data1, last1, swap_req, frame_sync,
    input  ack0, ack1, swap_pending, swap_done, display_page, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, last1, swap_req, frame_sync,
    output ack0, ack1, swap_pending, swap_done, display_page, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/h75_fb_write_arbiter.sv
// Two-writer arbiter into the HUB75 framebuffer write port, owning the double-buffered
// display/back page selection with frame-synchronous page swaps.
module h75_fb_write_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  h75_fb_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, BURST1} state_t;

  state_t            state_reg;
  logic              rr_last_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              display_page_reg;
  logic              swap_pending_reg;
  logic              swap_done_reg;
  logic              wr_en_reg;
  logic [ADDR_W:0]   wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic              grant0;
  logic              grant1;
  logic [CNT_W-1:0]  beat_cnt_next;
  logic              burst_end;
  logic              commit;

  // A pending swap fences new grants in IDLE so the back page is quiet when the swap commits;
  // an open port1 burst is allowed to finish regardless.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      unique case (state_reg)
        IDLE: begin
          if (!swap_pending_reg) begin
            if (bus.req0 && bus.req1) begin
              grant0 = rr_last_reg;
              grant1 = !rr_last_reg;
            end else begin
              grant0 = bus.req0;
              grant1 = bus.req1;
            end
          end
        end
        BURST1: grant1 = bus.req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    beat_cnt_next = (state_reg == IDLE) ? CNT_W'(1) : beat_cnt_reg + CNT_W'(1);
    burst_end     = bus.last1 || (beat_cnt_next == CNT_MAX);
    commit        = bus.frame_sync && swap_pending_reg && (state_reg == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      rr_last_reg      <= 1'b1;
      beat_cnt_reg     <= '0;
      display_page_reg <= 1'b0;
      swap_pending_reg <= 1'b0;
      swap_done_reg    <= 1'b0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
    end else begin
      wr_en_reg <= grant0 || grant1;
      if (grant0) begin
        wr_addr_reg <= {~display_page_reg, bus.addr0};
        wr_data_reg <= bus.data0;
        rr_last_reg <= 1'b0;
      end else if (grant1) begin
        wr_addr_reg  <= {~display_page_reg, bus.addr1};
        wr_data_reg  <= bus.data1;
        rr_last_reg  <= 1'b1;
        beat_cnt_reg <= beat_cnt_next;
        state_reg    <= burst_end ? IDLE : BURST1;
      end

      swap_done_reg <= commit;
      if (commit) begin
        display_page_reg <= ~display_page_reg;
        swap_pending_reg <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pending_reg <= 1'b1;
      end
    end
  end

  assign bus.ack0         = grant0;
  assign bus.ack1         = grant1;
  assign bus.swap_pending = swap_pending_reg;
  assign bus.swap_done    = swap_done_reg;
  assign bus.display_page = display_page_reg;
  assign bus.wr_en        = wr_en_reg;
  assign bus.wr_addr      = wr_addr_reg;
  assign bus.wr_data      = wr_data_reg;
endmodule

// File: tb/tb_h75_fb_write_arbiter.sv
// Bench for h75_fb_write_arbiter: queue-fed writers, a cycle-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, then randomized traffic and swaps.
module tb_h75_fb_write_arbiter;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 8;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  h75_fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  h75_fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- writer drivers: present queue heads, retire on observed ack ----------------
  beat_t q0[$];
  beat_t q1[$];
  bit ack0_s = 1'b0;
  bit ack1_s = 1'b0;

  always @(negedge clk) begin
    ack0_s = (bus.ack0 === 1'b1);
    ack1_s = (bus.ack1 === 1'b1);
  end

  always @(posedge clk) begin
    #1;
    if (ack0_s && q0.size() > 0) q0.pop_front();
    if (ack1_s && q1.size() > 0) q1.pop_front();
    if (q0.size() > 0) begin
      bus.req0 = 1'b1; bus.addr0 = q0[0].a; bus.data0 = q0[0].d;
    end else begin
      bus.req0 = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.req1 = 1'b1; bus.addr1 = q1[0].a; bus.data1 = q1[0].d; bus.last1 = q1[0].last;
    end else begin
      bus.req1 = 1'b0; bus.last1 = 1'b0;
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  bit                model_on = 1'b0;
  bit                m_disp, m_pend, m_done, m_wr_en;
  logic [ADDR_W:0]   m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  bit                m_burst;        // port1 currently owns the write port
  int                m_beats;        // beats taken in the current port1 ownership
  int                m_last_winner;  // port that won the most recent grant
  int                acc_log[$];     // per cycle: 0, 1, or -1 for no accept

  always @(negedge clk) begin
    bit e0, e1, commit;
    e0 = 1'b0;
    e1 = 1'b0;
    if (model_on) begin
      check("wr_en",        32'(bus.wr_en),        32'(m_wr_en));
      check("wr_addr",      32'(bus.wr_addr),      32'(m_wr_addr));
      check("wr_data",      32'(bus.wr_data),      32'(m_wr_data));
      check("display_page", 32'(bus.display_page), 32'(m_disp));
      check("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
      check("swap_done",    32'(bus.swap_done),    32'(m_done));
    end
    if (reset !== 1'b1) begin
      if (m_burst) begin
        e1 = (bus.req1 === 1'b1);
      end else if (!m_pend) begin
        if (bus.req0 === 1'b1 && bus.req1 === 1'b1) begin
          if (m_last_winner == 1) e0 = 1'b1; else e1 = 1'b1;
        end else begin
          e0 = (bus.req0 === 1'b1);
          e1 = (bus.req1 === 1'b1);
        end
      end
    end
    check("ack0", 32'(bus.ack0), 32'(e0));
    check("ack1", 32'(bus.ack1), 32'(e1));
    acc_log.push_back((bus.ack0 === 1'b1) ? 0 : ((bus.ack1 === 1'b1) ? 1 : -1));

    if (reset === 1'b1) begin
      m_disp = 0; m_pend = 0; m_done = 0; m_wr_en = 0;
      m_wr_addr = '0; m_wr_data = '0;
      m_burst = 0; m_beats = 0; m_last_winner = 1;
      model_on = 1'b1;
    end else begin
      commit = (bus.frame_sync === 1'b1) && m_pend && !m_burst;
      if (e0) begin
        m_wr_en = 1; m_wr_addr = {~m_disp, bus.addr0}; m_wr_data = bus.data0;
        m_last_winner = 0;
      end else if (e1) begin
        m_wr_en = 1; m_wr_addr = {~m_disp, bus.addr1}; m_wr_data = bus.data1;
        if (!m_burst) m_beats = 0;
        m_beats++;
        m_last_winner = 1;
        m_burst = !((bus.last1 === 1'b1) || m_beats == MAX_BURST);
      end else begin
        m_wr_en = 0;
      end
      m_done = commit;
      if (commit) begin
        m_disp = !m_disp; m_pend = 0;
      end else if (bus.swap_req === 1'b1) begin
        m_pend = 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic reset_pulse();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic check_seq(string name, int start, int exp[$]);
    int idx;
    idx = -1;
    for (int i = start; i < acc_log.size(); i++) begin
      if (acc_log[i] != -1) begin idx = i; break; end
    end
    if (idx < 0 || idx + exp.size() > acc_log.size()) begin
      checks++; errors++;
      $display("FAIL %s: accept sequence missing, got %0d entries, expected %0d", name,
               (idx < 0) ? 0 : acc_log.size() - idx, exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++)
        check($sformatf("%s[%0d]", name, k), 32'(acc_log[idx + k]), 32'(exp[k]));
    end
  endtask

  function automatic beat_t mk(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, bit last);
    beat_t b;
    b.a = a; b.d = d; b.last = last;
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int seq[$];
    bit seen;
    bus.swap_req = 1'b0; bus.frame_sync = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.last1 = 1'b0;
    bus.addr0 = '0; bus.data0 = '0; bus.addr1 = '0; bus.data1 = '0;

    // Reset held two cycles with both writers requesting.
    q0.push_back(mk(14'h0001, 16'h1111, 1'b0));
    q1.push_back(mk(14'h0002, 16'h2222, 1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_display_page", 32'(bus.display_page), 32'd0);
    check("rst_swap_pending", 32'(bus.swap_pending), 32'd0);
    q0.delete(); q1.delete();
    @(posedge clk); #2 reset = 1'b0;
    $display("txn reset: both requests held in reset, no acks");

    // Single port0 beat from idle.
    q0.push_back(mk(14'h0123, 16'hBEEF, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.ack0 === 1'b1);
    end
    check("p0_single_ack0", 32'(seen), 32'd1);
    @(negedge clk);
    check("p0_single_wr_en", 32'(bus.wr_en), 32'd1);
    check("p0_single_wr_addr", 32'(bus.wr_addr), 32'h4123);
    check("p0_single_wr_data", 32'(bus.wr_data), 32'hBEEF);
    $display("txn p0 single: addr=0x0123 data=0xBEEF -> wr_addr=0x%0h", bus.wr_addr);

    // Both requesting, port1 three-beat burst: P0,P1,P1,P1,P0.
    reset_pulse();
    start = acc_log.size();
    q0.push_back(mk(14'h0010, 16'hA000, 1'b0));
    q0.push_back(mk(14'h0011, 16'hA001, 1'b0));
    for (int i = 0; i < 3; i++) q1.push_back(mk(14'(14'h0200 + i), 16'(16'hB000 + i), i == 2));
    repeat (10) @(posedge clk);
    seq = '{0, 1, 1, 1, 0};
    check_seq("order3", start, seq);
    $display("txn burst3 interleave: checked P0,P1,P1,P1,P0");

    // Endless port1 burst capped at MAX_BURST, then port0 gets its turn.
    reset_pulse();
    start = acc_log.size();
    for (int i = 0; i < 12; i++) q1.push_back(mk(14'(14'h0300 + i), 16'(16'hC000 + i), 1'b0));
    @(posedge clk); #2;
    q0.push_back(mk(14'h0020, 16'hD000, 1'b0));
    repeat (14) @(posedge clk);
    seq = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    check_seq("burst_cap", start, seq);
    $display("txn burst cap: checked 8x P1, P0, P1");
    q0.delete(); q1.delete();

    // Swap from idle; port0 fenced until frame_sync commits.
    reset_pulse();
    @(posedge clk); #2;
    bus.swap_req = 1'b1;
    q0.push_back(mk(14'h0055, 16'h5A5A, 1'b0));
    @(posedge clk); #2 bus.swap_req = 1'b0;
    repeat (9) @(posedge clk);
    #2 bus.frame_sync = 1'b1;
    @(negedge clk);
    check("swap_fence_pending", 32'(bus.swap_pending), 32'd1);
    check("swap_fence_ack0", 32'(bus.ack0), 32'd0);
    @(posedge clk); #2 bus.frame_sync = 1'b0;
    @(negedge clk);
    check("swap_display_page", 32'(bus.display_page), 32'd1);
    check("swap_done_pulse", 32'(bus.swap_done), 32'd1);
    check("swap_post_ack0", 32'(bus.ack0), 32'd1);
    @(negedge clk);
    check("swap_post_wr_en", 32'(bus.wr_en), 32'd1);
    check("swap_post_wr_addr", 32'(bus.wr_addr), 32'h0055);
    check("swap_done_clears", 32'(bus.swap_done), 32'd0);
    $display("txn swap idle: display_page=%0d wr_addr=0x%0h", bus.display_page, bus.wr_addr);

    // frame_sync mid-burst is ignored; next frame_sync commits.
    reset_pulse();
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) q1.push_back(mk(14'(14'h0400 + i), 16'(16'hE000 + i), i == 7));
    repeat (3) @(posedge clk);
    #2 bus.swap_req = 1'b1;
    @(posedge clk); #2 bus.swap_req = 1'b0; bus.frame_sync = 1'b1;
    @(posedge clk); #2 bus.frame_sync = 1'b0;
    @(negedge clk);
    check("midburst_display_page", 32'(bus.display_page), 32'd0);
    check("midburst_pending", 32'(bus.swap_pending), 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midburst_after_display", 32'(bus.display_page), 32'd0);
    check("midburst_last_page", 32'(bus.wr_addr[ADDR_W]), 32'd1);
    check("midburst_last_data", 32'(bus.wr_data), 32'hE007);
    @(posedge clk); #2 bus.frame_sync = 1'b1;
    @(posedge clk); #2 bus.frame_sync = 1'b0;
    @(negedge clk);
    check("second_sync_display", 32'(bus.display_page), 32'd1);
    check("second_sync_done", 32'(bus.swap_done), 32'd1);
    $display("txn swap midburst: committed on second frame_sync");

    // Randomized traffic, swaps, frame syncs and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      if (q0.size() < 2 && $urandom_range(3) == 0)
        q0.push_back(mk(14'($urandom), 16'($urandom), 1'b0));
      if (q1.size() == 0 && $urandom_range(2) == 0) begin
        int len;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) q1.push_back(mk(14'($urandom), 16'($urandom), i == len - 1));
      end
      bus.swap_req   = ($urandom_range(39) == 0);
      bus.frame_sync = ($urandom_range(14) == 0);
      reset          = ($urandom_range(499) == 0);
      if (cyc % 500 == 0)
        $display("txn random: cycle %0d display_page=%0d errors so far=%0d", cyc, bus.display_page, errors);
    end
    @(posedge clk); #2;
    bus.swap_req = 1'b0; bus.frame_sync = 1'b0; reset = 1'b0;
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
